// File: rtl/discrete_range_sweep_controller_if.sv
// -----------------------------------------------------------------------------
// discrete_range_sweep_controller_if
// Result handshake between the sweep controller and the downstream sampler.
//   out_valid  : captured result available (controller -> sampler)
//   in_ready   : sampler accepts the result (sampler -> controller)
//   out_index  : variable index the result belongs to
//   out_start  : captured range start
//   out_end    : captured range end
//   out_equal  : captured equal flag
// Modports: master = controller side, slave = sampler side.
// -----------------------------------------------------------------------------
interface discrete_range_sweep_controller_if #(
   parameter int unsigned MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 2,
   parameter int unsigned MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 2
);
   logic                                         out_valid;
   logic                                         in_ready;
   logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  out_index;
   logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_start;
   logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_end;
   logic                                         out_equal;

   modport master (
      output out_valid,
      output out_index,
      output out_start,
      output out_end,
      output out_equal,
      input  in_ready
   );

   modport slave (
      input  out_valid,
      input  out_index,
      input  out_start,
      input  out_end,
      input  out_equal,
      output in_ready
   );
endinterface

// File: rtl/discrete_range_sweep_controller.sv
// -----------------------------------------------------------------------------
// discrete_range_sweep_controller
// Sequencer for the discrete range randomizer. On a start pulse it walks the
// variable indices 0..N-1; for each one it pulses the randomizer enable, waits
// the randomizer latency, captures start/end/equal and offers the result to the
// downstream sampler over a valid/ready handshake. A one-cycle done pulse marks
// the end of the sweep.
// Ports:
//   in_clock               : clock, rising edge
//   in_reset               : synchronous active-low reset
//   in_start               : sweep start pulse (only honoured while idle)
//   in_number_of_variables : number N of variables, latched on start
//   out_variable_index     : index presented to the randomizer
//   out_randomizer_enable  : one-cycle randomizer enable
//   in_range_start/end     : randomizer range outputs
//   in_range_equal         : randomizer equal flag
//   out_busy               : high whenever not idle
//   out_done               : one-cycle end-of-sweep pulse
//   result_if              : result handshake (master side)
// -----------------------------------------------------------------------------
module discrete_range_sweep_controller #(
   parameter int unsigned MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 2,
   parameter int unsigned MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 2,
   parameter int unsigned RANDOMIZER_LATENCY                = 1
) (
   input  logic                                         in_clock,
   input  logic                                         in_reset,
   input  logic                                         in_start,
   input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX:0]    in_number_of_variables,
   output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  out_variable_index,
   output logic                                         out_randomizer_enable,
   input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_range_start,
   input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_range_end,
   input  logic                                         in_range_equal,
   output logic                                         out_busy,
   output logic                                         out_done,
   discrete_range_sweep_controller_if.master            result_if
);

   localparam int unsigned IdxW = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
   localparam int unsigned ValW = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
   localparam int unsigned CntW = $clog2(RANDOMIZER_LATENCY + 1);

   typedef enum logic [2:0] {
      StIdle,
      StStep,
      StWait,
      StPresent,
      StDone
   } state_e;

   state_e            state_q;
   logic [IdxW:0]     count_q;
   logic [CntW-1:0]   lat_cnt_q;
   logic [IdxW-1:0]   index_q;
   logic              enable_q;
   logic              valid_q;
   logic [IdxW-1:0]   res_index_q;
   logic [ValW-1:0]   res_start_q;
   logic [ValW-1:0]   res_end_q;
   logic              res_equal_q;
   logic              busy_q;
   logic              done_q;

   logic [IdxW:0]     last_index;
   logic              is_last;
   logic              handshake;

   // Compared one bit wider than the index so N = 2^IdxW ends without wrapping.
   assign last_index = count_q - 1'b1;
   assign is_last    = ({1'b0, index_q} == last_index);
   assign handshake  = valid_q & result_if.in_ready;

   always_ff @(posedge in_clock) begin
      if (!in_reset) begin
         state_q     <= StIdle;
         count_q     <= '0;
         lat_cnt_q   <= '0;
         index_q     <= '0;
         enable_q    <= 1'b0;
         valid_q     <= 1'b0;
         res_index_q <= '0;
         res_start_q <= '0;
         res_end_q   <= '0;
         res_equal_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // Enable and done are single-cycle pulses raised on state entry.
         enable_q <= 1'b0;
         done_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_start) begin
                  busy_q <= 1'b1;
                  if (in_number_of_variables != '0) begin
                     count_q  <= in_number_of_variables;
                     index_q  <= '0;
                     enable_q <= 1'b1;
                     state_q  <= StStep;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            StStep: begin
               lat_cnt_q <= CntW'(RANDOMIZER_LATENCY);
               state_q   <= StWait;
            end
            StWait: begin
               lat_cnt_q <= lat_cnt_q - 1'b1;
               // Last wait cycle: randomizer outputs are valid now.
               if (lat_cnt_q == CntW'(1)) begin
                  res_index_q <= index_q;
                  res_start_q <= in_range_start;
                  res_end_q   <= in_range_end;
                  res_equal_q <= in_range_equal;
                  valid_q     <= 1'b1;
                  state_q     <= StPresent;
               end
            end
            StPresent: begin
               if (handshake) begin
                  valid_q <= 1'b0;
                  if (is_last) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     index_q  <= index_q + 1'b1;
                     enable_q <= 1'b1;
                     state_q  <= StStep;
                  end
               end
            end
            StDone: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign out_variable_index    = index_q;
   assign out_randomizer_enable = enable_q;
   assign out_busy              = busy_q;
   assign out_done              = done_q;

   assign result_if.out_valid = valid_q;
   assign result_if.out_index = res_index_q;
   assign result_if.out_start = res_start_q;
   assign result_if.out_end   = res_end_q;
   assign result_if.out_equal = res_equal_q;

endmodule
